packet_slot_allocator: RTL and testbench
========================================

# packet_slot_allocator

Owns the occupancy state of the packet controller's NUM_ENTRIES-slot packet buffer and serves allocation and release requests against it. Each cycle it selects a free slot with the free-index priority encoder (`next_free_index_comb`) and grants it to the single allocation requester. It also accepts slot releases, tracks the free-slot count and full/empty status, and flags illegal releases. It sits between the packet receive path (allocator) and the transmit/retire path (releaser).

## Interface
- NUM_ENTRIES, 8, number of buffer slots; legal range ≥ 2.
- IDX_W, $clog2(NUM_ENTRIES), slot index width; derived, not overridden.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc_req  input  1  request one slot; held high until granted.
- alloc_grant  output  1  registered one-cycle pulse; a slot was allocated.
- alloc_index  output  IDX_W  slot granted; valid only while alloc_grant=1.
- free_valid  input  1  release the slot at free_index this cycle.
- free_index  input  IDX_W  slot to release.
- in_use_bitmap  output  NUM_ENTRIES  registered occupancy; bit i=1 means slot i is allocated.
- free_count  output  IDX_W+1  registered number of free slots.
- full  output  1  free_count==0.
- empty  output  1  free_count==NUM_ENTRIES.
- err_double_free  output  1  sticky illegal-release flag.
- err_clear  input  1  clears err_double_free.

## Operation
- Free bitmap is the bitwise inverse of in_use_bitmap. It drives `next_free_index_comb` combinationally.
- Selection rule: the highest-indexed free slot wins. Example: with slots 0 and 1 free, slot 1 is chosen.
- Allocation fire:
  - alloc_fire = alloc_req && encoder valid, evaluated on current-cycle state.
  - On the edge where alloc_fire=1: set the selected bit in in_use_bitmap, register alloc_grant=1 and alloc_index=selected.
  - If no slot is free, alloc_fire=0, alloc_grant=0 and the request is held. No request is queued and none is dropped.
- Release:
  - Legal release: free_valid=1, free_index<NUM_ENTRIES and in_use_bitmap[free_index]=1. It clears that bit at the edge.
  - Illegal release: index out of range, or slot already free. It leaves the bitmap and count unchanged and sets err_double_free.
- Simultaneous alloc and free at the same edge:
  - Both apply.
  - The slot being freed is not eligible for allocation in that same cycle, because selection uses pre-edge state. It becomes allocatable the next cycle.
  - A release of the slot currently being allocated cannot occur, since that slot is free pre-edge; such a release is illegal.
- Count arithmetic: free_count_next = free_count − alloc_fire + legal_free. Width IDX_W+1 holds NUM_ENTRIES exactly. Underflow and overflow are impossible by construction; the verifier asserts this.
- err_double_free:
  - Sticky; set priority over err_clear when both occur in the same cycle.
  - Cleared by err_clear otherwise.
- No FSM beyond the occupancy register. The grant path is a 2-state pulse: IDLE → GRANT for one cycle on alloc_fire, otherwise back to IDLE.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - in_use_bitmap=0, free_count=NUM_ENTRIES, full=0, empty=1.
  - alloc_grant=0, alloc_index=0, err_double_free=0.
- Allocation latency: request seen at edge N, grant asserted in cycle N+1 with alloc_index. The requester deasserts alloc_req in the grant cycle if it wants exactly one slot.
- A held alloc_req yields one grant per cycle while slots remain (back-to-back).
- Release is visible in in_use_bitmap, free_count, full and empty the cycle after the edge.
- full/empty are decoded from the registered count, so they have the same timing as free_count.
- Reset asserted mid-operation: all slots become free immediately, any pending grant pulse is killed, and the error flag is cleared. After reset deasserts, the first allocation returns index NUM_ENTRIES−1.

## Test plan
- Reset → in_use_bitmap=8'h00, free_count=8, empty=1, full=0, alloc_grant=0, err_double_free=0.
- alloc_req held 4 cycles from reset → grants with alloc_index 7,6,5,4 on consecutive cycles; free_count=4, in_use_bitmap=8'hF0.
- From 8'hF0: free slot 6, then request one slot → alloc_index=6, bitmap back to 8'hF0.
- Fill all 8 slots, keep alloc_req high → full=1, no grant. Free slot 3 → alloc_grant=1 with index 3 two cycles after the free edge; full=1 again.
- When full, assert free_index=2 and alloc_req in the same cycle → no grant that cycle; grant index 2 the next cycle; free_count goes 0→1→0.
- Free slot 5 when it is not in use → err_double_free=1, bitmap and count unchanged, flag stays set. err_clear → 0. Assert rst mid-fill → all reset values immediately.

Source files
------------

// File: rtl/packet_slot_allocator.sv
// Occupancy tracker for the packet buffer: grants the highest-indexed free slot to the
// allocation requester, accepts releases, and keeps free count, full/empty and an error flag.
module packet_slot_allocator #(
    parameter int NUM_ENTRIES = 8,
    localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_req,
    output logic                   alloc_grant,
    output logic [IDX_W-1:0]       alloc_index,
    input  logic                   free_valid,
    input  logic [IDX_W-1:0]       free_index,
    output logic [NUM_ENTRIES-1:0] in_use_bitmap,
    output logic [IDX_W:0]         free_count,
    output logic                   full,
    output logic                   empty,
    output logic                   err_double_free,
    input  logic                   err_clear
);

    typedef enum logic {
        GRANT_IDLE,
        GRANT_PULSE
    } grant_state_e;

    grant_state_e           grant_q;
    logic [NUM_ENTRIES-1:0] in_use_q;
    logic [NUM_ENTRIES-1:0] in_use_d;
    logic [NUM_ENTRIES-1:0] free_bitmap;
    logic [IDX_W:0]         free_count_q;
    logic [IDX_W:0]         free_count_d;
    logic [IDX_W-1:0]       alloc_index_q;
    logic                   err_q;
    logic [IDX_W-1:0]       sel_index;
    logic                   sel_valid;
    logic                   alloc_fire;
    logic                   free_in_range;
    logic                   legal_free;
    logic                   illegal_free;

    assign free_bitmap = ~in_use_q;

    // Ascending scan so the last free slot seen, i.e. the highest index, wins.
    always_comb begin : next_free_index_comb
        sel_valid = 1'b0;
        sel_index = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_bitmap[i]) begin
                sel_valid = 1'b1;
                sel_index = IDX_W'(i);
            end
        end
    end

    assign alloc_fire    = alloc_req && sel_valid;
    assign free_in_range = ({1'b0, free_index} < (IDX_W + 1)'(NUM_ENTRIES));
    assign legal_free    = free_valid && free_in_range && in_use_q[free_index];
    assign illegal_free  = free_valid && !legal_free;

    // Selection and release legality both use pre-edge state, so the two never touch the same bit.
    always_comb begin
        in_use_d = in_use_q;
        if (alloc_fire) begin
            in_use_d[sel_index] = 1'b1;
        end
        if (legal_free) begin
            in_use_d[free_index] = 1'b0;
        end
    end

    assign free_count_d = free_count_q - (IDX_W + 1)'(alloc_fire) + (IDX_W + 1)'(legal_free);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q       <= GRANT_IDLE;
            in_use_q      <= '0;
            free_count_q  <= (IDX_W + 1)'(NUM_ENTRIES);
            alloc_index_q <= '0;
            err_q         <= 1'b0;
        end else begin
            grant_q      <= alloc_fire ? GRANT_PULSE : GRANT_IDLE;
            in_use_q     <= in_use_d;
            free_count_q <= free_count_d;
            if (alloc_fire) begin
                alloc_index_q <= sel_index;
            end
            if (illegal_free) begin
                err_q <= 1'b1;
            end else if (err_clear) begin
                err_q <= 1'b0;
            end
        end
    end

    assign alloc_grant     = (grant_q == GRANT_PULSE);
    assign alloc_index     = alloc_index_q;
    assign in_use_bitmap   = in_use_q;
    assign free_count      = free_count_q;
    assign full            = (free_count_q == '0);
    assign empty           = (free_count_q == (IDX_W + 1)'(NUM_ENTRIES));
    assign err_double_free = err_q;

endmodule

// File: tb/tb_packet_slot_allocator.sv
// Self-checking bench for packet_slot_allocator: directed scenarios plus a randomized run
// compared against a slot-list reference model.
module tb_packet_slot_allocator;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         alloc_req;
    logic         alloc_grant;
    logic [2:0]   alloc_index;
    logic         free_valid;
    logic [2:0]   free_index;
    logic [N-1:0] in_use_bitmap;
    logic [3:0]   free_count;
    logic         full;
    logic         empty;
    logic         err_double_free;
    logic         err_clear;

    int compared;
    int mismatched;

    bit   used [N];
    bit   expGrant;
    int   expIndex;
    bit   expErr;

    packet_slot_allocator #(.NUM_ENTRIES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_grant    (alloc_grant),
        .alloc_index    (alloc_index),
        .free_valid     (free_valid),
        .free_index     (free_index),
        .in_use_bitmap  (in_use_bitmap),
        .free_count     (free_count),
        .full           (full),
        .empty          (empty),
        .err_double_free(err_double_free),
        .err_clear      (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] modelBitmap();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = used[i];
        return b;
    endfunction

    function automatic int modelFree();
        int c = 0;
        for (int i = 0; i < N; i++) if (!used[i]) c++;
        return c;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        expGrant = 1'b0;
        expIndex = 0;
        expErr   = 1'b0;
    endtask

    // Apply the allocation/release rules to the model using the inputs present before the edge.
    task automatic modelEdge();
        int  pick;
        bit  legal;
        pick = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (!used[i]) begin
                pick = i;
                break;
            end
        end
        legal = free_valid && (int'(free_index) < N) && used[free_index];
        expGrant = alloc_req && (pick >= 0);
        if (expGrant) begin
            used[pick] = 1'b1;
            expIndex   = pick;
        end
        if (legal) used[free_index] = 1'b0;
        if (free_valid && !legal) expErr = 1'b1;
        else if (err_clear)       expErr = 1'b0;
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        modelReset();
        #3;
        compared++;
        if (in_use_bitmap !== 8'h00 || free_count !== 4'd8 || empty !== 1'b1 || full !== 1'b0 ||
            alloc_grant !== 1'b0 || alloc_index !== 3'd0 || err_double_free !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset: got bm=%h cnt=%0d empty=%b full=%b grant=%b idx=%0d err=%b, want bm=00 cnt=8 empty=1 full=0 grant=0 idx=0 err=0",
                     in_use_bitmap, free_count, empty, full, alloc_grant, alloc_index, err_double_free);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        alloc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (alloc_grant !== 1'b1 || alloc_index !== 3'(7 - k)) begin
                mismatched++;
                $display("[TB] FAIL b2b_grant%0d: got grant=%b idx=%0d, want grant=1 idx=%0d",
                         k, alloc_grant, alloc_index, 7 - k);
            end
        end
        alloc_req = 1'b0;
        compared++;
        if (free_count !== 4'd4 || in_use_bitmap !== 8'hF0) begin
            mismatched++;
            $display("[TB] FAIL b2b_state: got cnt=%0d bm=%h, want cnt=4 bm=f0", free_count, in_use_bitmap);
        end
        tick();
        compared++;
        if (alloc_grant !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_pulse_end: got grant=%b, want 0", alloc_grant);
        end
    endtask

    task automatic test_realloc();
        free_valid = 1'b1;
        free_index = 3'd6;
        tick();
        free_valid = 1'b0;
        compared++;
        if (in_use_bitmap !== 8'hB0 || free_count !== 4'd5) begin
            mismatched++;
            $display("[TB] FAIL realloc_free: got bm=%h cnt=%0d, want bm=b0 cnt=5", in_use_bitmap, free_count);
        end
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        compared++;
        if (alloc_grant !== 1'b1 || alloc_index !== 3'd6 || in_use_bitmap !== 8'hF0) begin
            mismatched++;
            $display("[TB] FAIL realloc_grant: got grant=%b idx=%0d bm=%h, want grant=1 idx=6 bm=f0",
                     alloc_grant, alloc_index, in_use_bitmap);
        end
        tick();
    endtask

    task automatic test_full_hold();
        alloc_req = 1'b1;
        repeat (4) tick();
        compared++;
        if (full !== 1'b1 || free_count !== 4'd0 || alloc_index !== 3'd0 || in_use_bitmap !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL fill: got full=%b cnt=%0d idx=%0d bm=%h, want full=1 cnt=0 idx=0 bm=ff",
                     full, free_count, alloc_index, in_use_bitmap);
        end
        tick();
        compared++;
        if (alloc_grant !== 1'b0 || full !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL full_no_grant: got grant=%b full=%b, want grant=0 full=1", alloc_grant, full);
        end
        free_valid = 1'b1;
        free_index = 3'd3;
        tick();
        free_valid = 1'b0;
        compared++;
        if (alloc_grant !== 1'b0 || full !== 1'b0 || free_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL full_release: got grant=%b full=%b cnt=%0d, want grant=0 full=0 cnt=1",
                     alloc_grant, full, free_count);
        end
        tick();
        alloc_req = 1'b0;
        compared++;
        if (alloc_grant !== 1'b1 || alloc_index !== 3'd3 || full !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL full_regrant: got grant=%b idx=%0d full=%b, want grant=1 idx=3 full=1",
                     alloc_grant, alloc_index, full);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_index = 3'd2;
        tick();
        free_valid = 1'b0;
        compared++;
        if (alloc_grant !== 1'b0 || free_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL simul_first: got grant=%b cnt=%0d, want grant=0 cnt=1", alloc_grant, free_count);
        end
        tick();
        alloc_req = 1'b0;
        compared++;
        if (alloc_grant !== 1'b1 || alloc_index !== 3'd2 || free_count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL simul_second: got grant=%b idx=%0d cnt=%0d, want grant=1 idx=2 cnt=0",
                     alloc_grant, alloc_index, free_count);
        end
        tick();
    endtask

    task automatic test_double_free();
        free_valid = 1'b1;
        free_index = 3'd5;
        tick();
        tick();
        free_valid = 1'b0;
        compared++;
        if (err_double_free !== 1'b1 || in_use_bitmap !== 8'hDF || free_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL dfree_set: got err=%b bm=%h cnt=%0d, want err=1 bm=df cnt=1",
                     err_double_free, in_use_bitmap, free_count);
        end
        tick();
        compared++;
        if (err_double_free !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL dfree_sticky: got err=%b, want 1", err_double_free);
        end
        err_clear = 1'b1;
        tick();
        compared++;
        if (err_double_free !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dfree_clear: got err=%b, want 0", err_double_free);
        end
        free_valid = 1'b1;
        tick();
        free_valid = 1'b0;
        compared++;
        if (err_double_free !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL dfree_set_priority: got err=%b, want 1", err_double_free);
        end
        tick();
        err_clear = 1'b0;
        compared++;
        if (err_double_free !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dfree_clear2: got err=%b, want 0", err_double_free);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_index = 3'd0;
        tick();
        free_valid = 1'b0;
        tick();
        rst = 1'b1;
        modelReset();
        #1;
        compared++;
        if (in_use_bitmap !== 8'h00 || free_count !== 4'd8 || empty !== 1'b1 || full !== 1'b0 ||
            alloc_grant !== 1'b0 || err_double_free !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got bm=%h cnt=%0d empty=%b full=%b grant=%b err=%b, want bm=00 cnt=8 empty=1 full=0 grant=0 err=0",
                     in_use_bitmap, free_count, empty, full, alloc_grant, err_double_free);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        alloc_req = 1'b0;
        compared++;
        if (alloc_grant !== 1'b1 || alloc_index !== 3'd7) begin
            mismatched++;
            $display("[TB] FAIL reset_first_grant: got grant=%b idx=%0d, want grant=1 idx=7",
                     alloc_grant, alloc_index);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alloc_req  = ($urandom_range(0, 1) == 1);
            free_valid = ($urandom_range(0, 2) != 0);
            free_index = 3'($urandom_range(0, N - 1));
            err_clear  = ($urandom_range(0, 7) == 0);
            tick();
            compared++;
            if (in_use_bitmap !== modelBitmap() || int'(free_count) != modelFree() ||
                full !== (modelFree() == 0) || empty !== (modelFree() == N)) begin
                mismatched++;
                $display("[TB] FAIL rand_occupancy@%0d: got bm=%h cnt=%0d full=%b empty=%b, want bm=%h cnt=%0d",
                         c, in_use_bitmap, free_count, full, empty, modelBitmap(), modelFree());
            end
            compared++;
            if (alloc_grant !== expGrant || (expGrant && int'(alloc_index) != expIndex)) begin
                mismatched++;
                $display("[TB] FAIL rand_grant@%0d: got grant=%b idx=%0d, want grant=%b idx=%0d",
                         c, alloc_grant, alloc_index, expGrant, expIndex);
            end
            compared++;
            if (err_double_free !== expErr) begin
                mismatched++;
                $display("[TB] FAIL rand_err@%0d: got err=%b, want %b", c, err_double_free, expErr);
            end
        end
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        err_clear  = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_index = 3'd0;
        err_clear  = 1'b0;
        rst        = 1'b1;
        test_reset();
        test_back_to_back();
        test_realloc();
        test_full_hold();
        test_simultaneous();
        test_double_free();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
